// File: rtl/sdram_responder_if.sv
// SDRAM device-side pin bundle shared by a controller (master) and the responder model (slave).
// Latency: none, wires only.
// Backpressure: none; the controller owns command timing and the responder reports errors.
// Ports: command/mask/address pins plus write data (master -> slave);
//        read data, drive enable and status outputs (slave -> master).
interface sdram_responder_if;
  logic        SDRAM_nCS;
  logic        SDRAM_nRAS;
  logic        SDRAM_nCAS;
  logic        SDRAM_nWE;
  logic        SDRAM_CKE;
  logic        SDRAM_DQML;
  logic        SDRAM_DQMH;
  logic [12:0] SDRAM_A;
  logic [1:0]  SDRAM_BA;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic        cmd_err;
  logic [2:0]  err_code;
  logic        mode_valid;
  logic [15:0] refresh_count;

  modport master (
    output SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE,
           SDRAM_DQML, SDRAM_DQMH, SDRAM_A, SDRAM_BA, dq_i,
    input  dq_o, dq_oe, cmd_err, err_code, mode_valid, refresh_count
  );

  modport slave (
    input  SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE,
           SDRAM_DQML, SDRAM_DQMH, SDRAM_A, SDRAM_BA, dq_i,
    output dq_o, dq_oe, cmd_err, err_code, mode_valid, refresh_count
  );
endinterface

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: decodes commands, checks bank/mode legality, stores 16-bit words.
// Latency: WRITE stored at the command edge; READ data presented for the cycle ending at edge READ+CL.
// Backpressure: none; illegal commands are dropped with a cmd_err pulse and a held err_code.
// Ports: clk, reset_n (async active-low), bus (slave side of sdram_responder_if).
module sdram_responder #(
  parameter int MEM_AW = 12,
  parameter int TRCD   = 2
) (
  input logic               clk,
  input logic               reset_n,
  sdram_responder_if.slave  bus
);

  localparam int DEPTH = 1 << MEM_AW;

  // Command decode; deselect, CKE low, 111 and 110 all fall through as NOP.
  logic       cmd_en;
  logic [2:0] rcw;
  logic       is_act, is_rd, is_wr, is_pre, is_aref, is_lmr;

  assign cmd_en  = !bus.SDRAM_nCS && bus.SDRAM_CKE;
  assign rcw     = {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE};
  assign is_act  = cmd_en && (rcw == 3'b011);
  assign is_rd   = cmd_en && (rcw == 3'b101);
  assign is_wr   = cmd_en && (rcw == 3'b100);
  assign is_pre  = cmd_en && (rcw == 3'b010);
  assign is_aref = cmd_en && (rcw == 3'b001);
  assign is_lmr  = cmd_en && (rcw == 3'b000);

  // Bank and mode state.
  logic [3:0]  bank_open;
  logic [12:0] bank_row [4];
  logic [7:0]  age      [4];
  logic [9:0]  mode_reg;
  logic        mode_valid;

  logic [1:0]  ba;
  logic        any_open;
  logic        lmr_legal;
  logic [2:0]  rej_code;
  logic        accept;

  assign ba        = bus.SDRAM_BA;
  assign any_open  = |bank_open;
  assign lmr_legal = (bus.SDRAM_A[2:0] == 3'd0) &&
                     ((bus.SDRAM_A[6:4] == 3'd2) || (bus.SDRAM_A[6:4] == 3'd3));

  // Causes are evaluated from highest code to lowest so the lowest applicable code wins.
  // age counts edges since ACTIVE minus one, hence the +1 in the tRCD test.
  always_comb begin
    rej_code = 3'd0;
    if (is_lmr && !lmr_legal)                                          rej_code = 3'd6;
    if ((is_aref || is_lmr) && any_open)                               rej_code = 3'd5;
    if ((is_rd || is_wr) && bank_open[ba] && (int'(age[ba]) + 1 < TRCD)) rej_code = 3'd4;
    if (is_act && bank_open[ba])                                       rej_code = 3'd3;
    if ((is_rd || is_wr) && !bank_open[ba])                            rej_code = 3'd2;
    if ((is_act || is_rd || is_wr) && !mode_valid)                     rej_code = 3'd1;
  end

  assign accept = (rej_code == 3'd0);

  // Storage: word index is the low MEM_AW bits of {bank, open row, column}.
  logic [15:0]       mem [DEPTH];
  logic [23:0]       full_idx;
  logic [MEM_AW-1:0] widx;
  logic [15:0]       rd_word;

  assign full_idx = {ba, bank_row[ba], bus.SDRAM_A[8:0]};
  assign widx     = full_idx[MEM_AW-1:0];
  assign rd_word  = {bus.SDRAM_DQMH ? 8'h00 : mem[widx][15:8],
                     bus.SDRAM_DQML ? 8'h00 : mem[widx][7:0]};

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (is_wr && accept) begin
      if (!bus.SDRAM_DQML) mem[widx][7:0]  <= bus.dq_i[7:0];
      if (!bus.SDRAM_DQMH) mem[widx][15:8] <= bus.dq_i[15:8];
    end
  end

  // Read pipeline: s0 holds the word captured at the READ edge; CL=3 reads take one more hop via s1.
  logic        s0_vld, s0_cl3, s1_vld;
  logic [15:0] s0_dat, s1_dat;
  logic [15:0] refresh_count;
  logic        cmd_err;
  logic [2:0]  err_code;
  logic        dq_oe;
  logic [15:0] dq_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_open     <= '0;
      for (int b = 0; b < 4; b++) begin
        bank_row[b] <= '0;
        age[b]      <= '0;
      end
      mode_reg      <= '0;
      mode_valid    <= 1'b0;
      refresh_count <= '0;
      cmd_err       <= 1'b0;
      err_code      <= '0;
      s0_vld        <= 1'b0;
      s0_cl3        <= 1'b0;
      s0_dat        <= '0;
      s1_vld        <= 1'b0;
      s1_dat        <= '0;
      dq_oe         <= 1'b0;
      dq_o          <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (age[b] != 8'hFF) age[b] <= age[b] + 8'd1;
      end

      cmd_err <= !accept;
      if (!accept) err_code <= rej_code;

      if (accept) begin
        if (is_act) begin
          bank_open[ba] <= 1'b1;
          bank_row[ba]  <= bus.SDRAM_A;
          age[ba]       <= '0;
        end
        if (is_pre) begin
          if (bus.SDRAM_A[10]) bank_open     <= '0;
          else                 bank_open[ba] <= 1'b0;
        end
        // Auto-precharge closes the bank once this access has used the open row.
        if ((is_rd || is_wr) && bus.SDRAM_A[10]) bank_open[ba] <= 1'b0;
        if (is_aref) refresh_count <= refresh_count + 16'd1;
        if (is_lmr) begin
          mode_reg   <= bus.SDRAM_A[9:0];
          mode_valid <= 1'b1;
        end
      end

      s0_vld <= is_rd && accept;
      s0_cl3 <= (mode_reg[6:4] == 3'd3);
      s0_dat <= rd_word;
      s1_vld <= s0_vld && s0_cl3;
      s1_dat <= s0_dat;

      // The older (CL=3) entry wins if a CL change makes two entries land together.
      if (s1_vld) begin
        dq_oe <= 1'b1;
        dq_o  <= s1_dat;
      end else if (s0_vld && !s0_cl3) begin
        dq_oe <= 1'b1;
        dq_o  <= s0_dat;
      end else begin
        dq_oe <= 1'b0;
        dq_o  <= '0;
      end
    end
  end

  assign bus.dq_o          = dq_o;
  assign bus.dq_oe         = dq_oe;
  assign bus.cmd_err       = cmd_err;
  assign bus.err_code      = err_code;
  assign bus.mode_valid    = mode_valid;
  assign bus.refresh_count = refresh_count;

  // Address/mode bits that do not take part in indexing or latency selection.
  logic unused_bits;
  assign unused_bits = ^{full_idx, mode_reg[9:7], mode_reg[3:0]};

endmodule

// File: tb/tb_sdram_responder.sv
module tb_sdram_responder;

  localparam logic [2:0] C_ACT  = 3'b011;
  localparam logic [2:0] C_RD   = 3'b101;
  localparam logic [2:0] C_WR   = 3'b100;
  localparam logic [2:0] C_PRE  = 3'b010;
  localparam logic [2:0] C_AREF = 3'b001;
  localparam logic [2:0] C_LMR  = 3'b000;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  logic err_seen;

  sdram_responder_if bus ();

  sdram_responder #(.MEM_AW(12), .TRCD(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_pins();
    bus.SDRAM_nCS  = 1'b1;
    bus.SDRAM_CKE  = 1'b1;
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = 3'b111;
    bus.SDRAM_DQML = 1'b0;
    bus.SDRAM_DQMH = 1'b0;
    bus.SDRAM_A    = '0;
    bus.SDRAM_BA   = '0;
    bus.dq_i       = '0;
  endtask

  // Called at a falling edge; the command is sampled at the next rising edge,
  // and the task returns at the following falling edge with the pins idle.
  task automatic cmd(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] a,
                     input logic [15:0] d, input logic [1:0] dqm);
    bus.SDRAM_nCS  = 1'b0;
    bus.SDRAM_CKE  = 1'b1;
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = rcw;
    bus.SDRAM_BA   = ba;
    bus.SDRAM_A    = a;
    bus.dq_i       = d;
    {bus.SDRAM_DQMH, bus.SDRAM_DQML} = dqm;
    @(posedge clk);
    @(negedge clk);
    idle_pins();
    err_seen = err_seen | bus.cmd_err;
  endtask

  task automatic nop();
    @(posedge clk);
    @(negedge clk);
    err_seen = err_seen | bus.cmd_err;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    err_seen = 1'b0;
    reset_n  = 1'b0;
    idle_pins();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_mode_valid", {15'd0, bus.mode_valid}, 16'd0);
    check("rst_refresh",    bus.refresh_count,       16'd0);
    check("rst_cmd_err",    {15'd0, bus.cmd_err},    16'd0);
    check("rst_err_code",   {13'd0, bus.err_code},   16'd0);
    check("rst_dq_oe",      {15'd0, bus.dq_oe},      16'd0);
    check("rst_dq_o",       bus.dq_o,                16'd0);
    reset_n = 1'b1;
    nop();

    // ACTIVE before a mode is loaded -> code 1, pulse lasts one cycle, code held
    cmd(C_ACT, 2'd0, 13'd1, 16'd0, 2'b00);
    check("nomode_err",  {15'd0, bus.cmd_err},  16'd1);
    check("nomode_code", {13'd0, bus.err_code}, 16'd1);
    nop();
    check("nomode_pulse", {15'd0, bus.cmd_err},  16'd0);
    check("nomode_held",  {13'd0, bus.err_code}, 16'd1);

    // Init: precharge all, 8 refreshes, mode CL=2
    err_seen = 1'b0;
    cmd(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
    for (int i = 0; i < 8; i++) cmd(C_AREF, 2'd0, 13'd0, 16'd0, 2'b00);
    cmd(C_LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    check("init_mode_valid", {15'd0, bus.mode_valid}, 16'd1);
    check("init_refresh",    bus.refresh_count,       16'd8);
    check("init_no_err",     {15'd0, err_seen},       16'd0);

    // CKE low: an AUTO_REFRESH encoding is ignored
    bus.SDRAM_nCS = 1'b0;
    bus.SDRAM_CKE = 1'b0;
    {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_AREF;
    nop();
    idle_pins();
    check("cke_low_refresh", bus.refresh_count, 16'd8);

    // ACTIVE bank1 row5, WRITE col3, READ col3 with CL=2
    cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
    nop();
    cmd(C_WR, 2'd1, 13'd3, 16'hA55A, 2'b00);
    check("wr_ok", {15'd0, bus.cmd_err}, 16'd0);
    cmd(C_RD, 2'd1, 13'd3, 16'd0, 2'b00);
    check("rd_oe_e1", {15'd0, bus.dq_oe}, 16'd0);
    nop();
    check("rd_oe_e2", {15'd0, bus.dq_oe}, 16'd1);
    check("rd_dat",   bus.dq_o,           16'hA55A);
    nop();
    check("rd_oe_e3", {15'd0, bus.dq_oe}, 16'd0);

    // Byte-masked write, then back-to-back reads incl. a DQML-masked read
    cmd(C_WR, 2'd1, 13'd4, 16'hFFFF, 2'b00);
    cmd(C_WR, 2'd1, 13'd4, 16'h1234, 2'b10);
    cmd(C_RD, 2'd1, 13'd3, 16'd0, 2'b01);
    cmd(C_RD, 2'd1, 13'd4, 16'd0, 2'b00);
    check("b2b_oe1",  {15'd0, bus.dq_oe}, 16'd1);
    check("b2b_dqml", bus.dq_o,           16'hA500);
    // Overwrite col4 right after its READ; captured data must not change
    cmd(C_WR, 2'd1, 13'd4, 16'h0000, 2'b00);
    check("b2b_oe2",  {15'd0, bus.dq_oe}, 16'd1);
    check("b2b_dqmh", bus.dq_o,           16'hFF34);
    nop();
    check("b2b_oe3", {15'd0, bus.dq_oe}, 16'd0);

    // READ one cycle after ACTIVE -> code 4, no output
    cmd(C_ACT, 2'd0, 13'd7, 16'd0, 2'b00);
    cmd(C_RD, 2'd0, 13'd0, 16'd0, 2'b00);
    check("trcd_err",  {15'd0, bus.cmd_err},  16'd1);
    check("trcd_code", {13'd0, bus.err_code}, 16'd4);
    nop();
    check("trcd_oe_a", {15'd0, bus.dq_oe}, 16'd0);
    nop();
    check("trcd_oe_b", {15'd0, bus.dq_oe}, 16'd0);

    // READ to closed bank 3 -> code 2; ACTIVE to open bank 1 -> code 3
    cmd(C_RD, 2'd3, 13'd0, 16'd0, 2'b00);
    check("closed_code", {13'd0, bus.err_code}, 16'd2);
    cmd(C_ACT, 2'd1, 13'd9, 16'd0, 2'b00);
    check("open_code", {13'd0, bus.err_code}, 16'd3);

    // READ with auto-precharge, then another READ to the now-closed bank
    cmd(C_RD, 2'd1, 13'h403, 16'd0, 2'b00);
    check("ap_ok", {15'd0, bus.cmd_err}, 16'd0);
    cmd(C_RD, 2'd1, 13'd3, 16'd0, 2'b00);
    check("ap_closed_code", {13'd0, bus.err_code}, 16'd2);
    check("ap_rd_oe",       {15'd0, bus.dq_oe},    16'd1);
    check("ap_rd_dat",      bus.dq_o,              16'hA55A);

    // Refresh / mode rejections with banks open
    cmd(C_ACT, 2'd2, 13'd0, 16'd0, 2'b00);
    cmd(C_AREF, 2'd0, 13'd0, 16'd0, 2'b00);
    check("aref_open_code", {13'd0, bus.err_code}, 16'd5);
    check("aref_open_cnt",  bus.refresh_count,     16'd8);
    cmd(C_PRE, 2'd2, 13'd0, 16'd0, 2'b00);
    cmd(C_AREF, 2'd0, 13'd0, 16'd0, 2'b00);
    check("aref_bank0_code", {13'd0, bus.err_code}, 16'd5);
    cmd(C_PRE, 2'd0, 13'd0, 16'd0, 2'b00);
    cmd(C_AREF, 2'd0, 13'd0, 16'd0, 2'b00);
    check("aref_ok_err", {15'd0, bus.cmd_err}, 16'd0);
    check("aref_ok_cnt", bus.refresh_count,    16'd9);
    cmd(C_LMR, 2'd0, 13'h231, 16'd0, 2'b00);
    check("lmr_bad_err",  {15'd0, bus.cmd_err},    16'd1);
    check("lmr_bad_code", {13'd0, bus.err_code},   16'd6);
    check("lmr_bad_mode", {15'd0, bus.mode_valid}, 16'd1);
    nop();
    check("lmr_code_held", {13'd0, bus.err_code}, 16'd6);

    // Reset during a pending read
    cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
    nop();
    cmd(C_RD, 2'd1, 13'd3, 16'd0, 2'b00);
    reset_n = 1'b0;
    nop();
    check("mid_rst_oe", {15'd0, bus.dq_oe}, 16'd0);
    reset_n = 1'b1;
    nop();
    check("post_rst_oe",    {15'd0, bus.dq_oe},      16'd0);
    check("post_rst_mode",  {15'd0, bus.mode_valid}, 16'd0);
    check("post_rst_count", bus.refresh_count,       16'd0);

    // Re-init and confirm storage survived
    cmd(C_LMR, 2'd0, 13'h220, 16'd0, 2'b00);
    cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
    nop();
    cmd(C_RD, 2'd1, 13'd3, 16'd0, 2'b00);
    check("reinit_rd_err", {15'd0, bus.cmd_err}, 16'd0);
    nop();
    check("reinit_oe",  {15'd0, bus.dq_oe}, 16'd1);
    check("reinit_dat", bus.dq_o,           16'hA55A);
    nop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
